// File: rtl/speed_pkg.sv
// rtl/speed_pkg.sv - shared types and defaults for the speed sampler
package speed_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_EOC,
        PUBLISH
    } sampler_state_t;

    localparam int DEFAULT_SAMPLE_WIDTH = 12;
    localparam int DEFAULT_OUT_WIDTH    = 8;
    localparam int DEFAULT_AVG_LOG2     = 3;
    localparam int DEFAULT_DEADZONE     = 8;

    // A lost conversion is declared after 20 ms of the 100 MHz system clock.
    localparam int CLK_FREQ_HZ            = 100_000_000;
    localparam int EOC_TIMEOUT_MS         = 20;
    localparam int DEFAULT_TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000 * EOC_TIMEOUT_MS;

endpackage

// File: rtl/speed_sampler_if.sv
// rtl/speed_sampler_if.sv - ADC conversion request / end-of-conversion handshake
interface speed_sampler_if
    import speed_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH
);
    logic                    conv_start;
    logic                    adc_eoc;
    logic [SAMPLE_WIDTH-1:0] adc_data;

    modport master (output conv_start, input adc_eoc, input adc_data);
    modport slave  (input conv_start, output adc_eoc, output adc_data);
endinterface

// File: rtl/eoc_watchdog.sv
// rtl/eoc_watchdog.sv - cycle counter flagging a conversion that never completed
module eoc_watchdog
    import speed_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expired = run && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

    // Holds at the limit; the sampler leaves WAIT_EOC on expiry and clears it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/speed_sampler.sv
// rtl/speed_sampler.sv - averages ADC samples into a frame-synchronous ball speed
module speed_sampler
    import speed_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = DEFAULT_SAMPLE_WIDTH,
    parameter int AVG_LOG2       = DEFAULT_AVG_LOG2,
    parameter int OUT_WIDTH      = DEFAULT_OUT_WIDTH,
    parameter int DEADZONE       = DEFAULT_DEADZONE,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 frame_end,
    speed_sampler_if.master      adc,
    output logic [OUT_WIDTH-1:0] move_speed,
    output logic                 speed_valid,
    output logic                 stale
);
    localparam int ACC_W       = SAMPLE_WIDTH + AVG_LOG2;
    localparam int CNT_W       = AVG_LOG2 + 1;
    localparam int SCALE_SHIFT = AVG_LOG2 + SAMPLE_WIDTH - OUT_WIDTH;

    sampler_state_t         state;
    sampler_state_t         nextState;
    logic [ACC_W-1:0]       acc;
    logic [CNT_W-1:0]       count;
    logic [OUT_WIDTH-1:0]   pending;
    logic [OUT_WIDTH-1:0]   scaled;
    logic                   pendingValid;
    logic                   convStart;
    logic                   expired;
    logic                   lastSample;

    assign lastSample     = (count == CNT_W'((1 << AVG_LOG2) - 1));
    // Average and top-bit scaling folded into one truncating shift.
    assign scaled         = OUT_WIDTH'(acc >> SCALE_SHIFT);
    assign adc.conv_start = convStart;

    eoc_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == REQUEST || !enable),
        .run    (state == WAIT_EOC),
        .expired(expired)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (enable) nextState = REQUEST;
            REQUEST:  nextState = WAIT_EOC;
            WAIT_EOC: begin
                if (adc.adc_eoc) begin
                    nextState = lastSample ? PUBLISH : REQUEST;
                end else if (expired) begin
                    nextState = REQUEST;
                end
            end
            PUBLISH:  nextState = REQUEST;
            default:  nextState = IDLE;
        endcase
        if (!enable) nextState = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            convStart <= 1'b0;
        end else begin
            state     <= nextState;
            convStart <= (nextState == REQUEST);
        end
    end

    // PUBLISH is evaluated after the frame hand-off so a same-cycle result stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc          <= '0;
            count        <= '0;
            pending      <= '0;
            pendingValid <= 1'b0;
            move_speed   <= '0;
            speed_valid  <= 1'b0;
            stale        <= 1'b0;
        end else begin
            if (frame_end) begin
                if (!enable) begin
                    move_speed  <= '0;
                    speed_valid <= 1'b0;
                end else if (pendingValid) begin
                    move_speed   <= pending;
                    speed_valid  <= 1'b1;
                    pendingValid <= 1'b0;
                end
            end

            if (!enable) begin
                acc          <= '0;
                count        <= '0;
                pendingValid <= 1'b0;
            end else begin
                case (state)
                    WAIT_EOC: begin
                        if (adc.adc_eoc) begin
                            acc   <= acc + ACC_W'(adc.adc_data);
                            count <= count + 1'b1;
                            stale <= 1'b0;
                        end else if (expired) begin
                            stale <= 1'b1;
                        end
                    end
                    PUBLISH: begin
                        pending      <= (scaled < OUT_WIDTH'(DEADZONE)) ? '0 : scaled;
                        pendingValid <= 1'b1;
                        acc          <= '0;
                        count        <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_speed_sampler.sv
// tb/tb_speed_sampler.sv - directed self-checking bench for speed_sampler
module tb_speed_sampler;
    import speed_pkg::*;

    localparam int TMO        = 100;
    localparam int RESP_DELAY = 20;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       enable    = 1'b0;
    logic       frame_end = 1'b0;
    logic [7:0] move_speed;
    logic       speed_valid;
    logic       stale;

    speed_sampler_if #(.SAMPLE_WIDTH(12)) adc();

    speed_sampler #(
        .SAMPLE_WIDTH  (12),
        .AVG_LOG2      (3),
        .OUT_WIDTH     (8),
        .DEADZONE      (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_end  (frame_end),
        .adc        (adc),
        .move_speed (move_speed),
        .speed_valid(speed_valid),
        .stale      (stale)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [11:0] sampleQ[$];
    int respWait    = 0;
    int eocCount    = 0;
    int convCount   = 0;
    int convAtLast  = 0;
    int cyc         = 0;
    int lastConvCyc = 0;
    int convGap     = 0;
    int frameCount  = 0;
    int frameReqs   = 0;
    int frameServed = 0;
    int lateReqs    = 0;
    int lateServed  = 0;
    bit frameHigh   = 0;
    bit raceArm     = 0;
    bit raceDone    = 0;
    bit raceFire    = 0;

    // ADC model and frame_end driver, acting on falling edges.
    initial begin
        adc.adc_eoc  = 1'b0;
        adc.adc_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            adc.adc_eoc = 1'b0;
            if (frameHigh) begin
                frame_end = 1'b0;
                frameHigh = 0;
                frameCount++;
            end else if (raceFire || frameServed != frameReqs) begin
                frame_end = 1'b1;
                frameHigh = 1;
                if (raceFire) raceFire = 0;
                else frameServed++;
            end
            if (lateServed != lateReqs) begin
                adc.adc_data = 12'hFFF;
                adc.adc_eoc  = 1'b1;
                lateServed++;
            end else if (respWait > 0) begin
                respWait--;
                if (respWait == 0 && sampleQ.size() > 0) begin
                    adc.adc_data = sampleQ.pop_front();
                    adc.adc_eoc  = 1'b1;
                    eocCount++;
                    if (sampleQ.size() == 0) begin
                        convAtLast = convCount;
                        if (raceArm && !raceDone) begin
                            raceFire = 1;
                            raceDone = 1;
                        end
                    end
                end
            end
            if (adc.conv_start) begin
                convCount++;
                convGap     = cyc - lastConvCyc;
                lastConvCyc = cyc;
                respWait    = RESP_DELAY;
            end
            if (reset || !enable) respWait = 0;
        end
    end

    task automatic checkVal(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pushN(input logic [11:0] d, input int n);
        for (int i = 0; i < n; i++) sampleQ.push_back(d);
    endtask

    task automatic waitEocs(input int target, input string tag);
        for (int i = 0; i < 3000 && eocCount < target; i++) tick();
        if (eocCount < target) checkVal({tag, "_eoc_wait"}, eocCount, target);
    endtask

    task automatic pulseFrame();
        int start;
        start = frameCount;
        frameReqs++;
        for (int i = 0; i < 20 && frameCount == start; i++) tick();
        if (frameCount == start) checkVal("frame_wait", frameCount, start + 1);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "bench hung");
    end

    initial begin
        int base;
        int c;

        tick();
        tick();
        checkVal("rst_conv_start", int'(adc.conv_start), 0);
        checkVal("rst_move_speed", int'(move_speed), 0);
        checkVal("rst_speed_valid", int'(speed_valid), 0);
        checkVal("rst_stale", int'(stale), 0);
        reset = 1'b0;
        tick();

        // nominal: 8 x 0x800 -> 0x80
        base = eocCount;
        pushN(12'h800, 8);
        enable = 1'b1;
        waitEocs(base + 8, "nom");
        tick();
        checkVal("nom_conv_pulses", convAtLast, 8);
        checkVal("nom_hold_speed", int'(move_speed), 0);
        checkVal("nom_hold_valid", int'(speed_valid), 0);
        pulseFrame();
        checkVal("nom_speed", int'(move_speed), 8'h80);
        checkVal("nom_valid", int'(speed_valid), 1);

        // reset after 5 samples discards the partial sum
        base = eocCount;
        pushN(12'hFFF, 5);
        waitEocs(base + 5, "rstmid");
        reset = 1'b1;
        tick();
        checkVal("rstmid_conv_start", int'(adc.conv_start), 0);
        checkVal("rstmid_speed", int'(move_speed), 0);
        checkVal("rstmid_valid", int'(speed_valid), 0);
        checkVal("rstmid_stale", int'(stale), 0);
        reset = 1'b0;
        base = eocCount;
        pushN(12'h200, 8);
        waitEocs(base + 8, "rstmid2");
        tick();
        pulseFrame();
        checkVal("rstmid_new_speed", int'(move_speed), 8'h20);

        // deadzone: avg 0x050 scales to 5 -> 0
        base = eocCount;
        pushN(12'h000, 4);
        pushN(12'h0A0, 4);
        waitEocs(base + 8, "dz");
        tick();
        pulseFrame();
        checkVal("dz_speed", int'(move_speed), 0);
        checkVal("dz_valid", int'(speed_valid), 1);
        base = eocCount;
        pushN(12'hFFF, 8);
        waitEocs(base + 8, "full");
        tick();
        pulseFrame();
        checkVal("full_speed", int'(move_speed), 8'hFF);

        // frame_end in the PUBLISH cycle: old 0x40 now, new 0x90 next frame
        base = eocCount;
        pushN(12'h400, 8);
        waitEocs(base + 8, "race_a");
        tick();
        tick();
        raceArm = 1;
        c = frameCount;
        base = eocCount;
        pushN(12'h900, 8);
        waitEocs(base + 8, "race_b");
        for (int i = 0; i < 20 && frameCount == c; i++) tick();
        checkVal("race_old_speed", int'(move_speed), 8'h40);
        pulseFrame();
        checkVal("race_new_speed", int'(move_speed), 8'h90);

        // timeout: withheld conversion re-issued with stale set
        reset = 1'b1;
        tick();
        reset = 1'b0;
        base = convCount;
        for (int i = 0; i < 400 && convCount < base + 2; i++) tick();
        checkVal("tmo_conv_gap", convGap, TMO + 1);
        checkVal("tmo_stale_set", int'(stale), 1);
        base = eocCount;
        pushN(12'h400, 8);
        waitEocs(base + 1, "tmo_a");
        checkVal("tmo_stale_clr", int'(stale), 0);
        waitEocs(base + 8, "tmo_b");
        tick();
        pulseFrame();
        checkVal("tmo_speed", int'(move_speed), 8'h40);

        // enable drop during WAIT_EOC, late eoc ignored
        base = eocCount;
        pushN(12'hFFF, 2);
        waitEocs(base + 2, "en");
        c = convCount;
        for (int i = 0; i < 50 && convCount == c; i++) tick();
        enable = 1'b0;
        tick();
        lateReqs++;
        c = convCount;
        repeat (30) tick();
        checkVal("en_no_conv", convCount, c);
        pulseFrame();
        checkVal("en_speed", int'(move_speed), 0);
        checkVal("en_valid", int'(speed_valid), 0);
        enable = 1'b1;
        base = eocCount;
        pushN(12'h100, 8);
        waitEocs(base + 8, "en2");
        tick();
        pulseFrame();
        checkVal("en_resume_speed", int'(move_speed), 8'h10);
        checkVal("en_resume_valid", int'(speed_valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
